// File: rtl/key_event_gen.sv
// Push-button front end: 2-FF synchroniser, tick-sampled debounce and registered
// press/release/auto-repeat pulses, one independent lane per key.

module key_event_lane #(
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_DELAY     = 64,
  parameter int REPEAT_RATE      = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_tick,
  input  logic i_s,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_down,
  output logic o_up,
  output logic o_repeat,
  output logic o_long
);
  localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int PW = $clog2(REPEAT_RATE + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_RPT  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [PW-1:0] PH_LAST   = PW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  state_t        r_state;
  logic [DW-1:0] r_deb;
  logic [HW-1:0] r_hold;
  logic [PW-1:0] r_phase;
  logic          r_level, r_down, r_up, r_repeat, r_long;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_deb    <= '0;
      r_hold   <= '0;
      r_phase  <= '0;
      r_level  <= 1'b0;
      r_down   <= 1'b0;
      r_up     <= 1'b0;
      r_repeat <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      r_down   <= 1'b0;
      r_up     <= 1'b0;
      r_repeat <= 1'b0;
      if (i_tick) begin
        case (r_state)
          IDLE: if (i_s) begin
            if (DEBOUNCE_SAMPLES == 1) begin
              r_state <= HELD;
              r_level <= 1'b1;
              r_down  <= 1'b1;
            end else begin
              r_state <= PRESS_CHK;
              r_deb   <= DW'(1);
            end
          end
          PRESS_CHK: if (!i_s) begin
            r_state <= IDLE;
            r_deb   <= '0;
          end else if (r_deb == DEB_LAST) begin
            r_state <= HELD;
            r_deb   <= '0;
            r_level <= 1'b1;
            r_down  <= 1'b1;
          end else begin
            r_deb <= r_deb + 1'b1;
          end
          HELD: if (i_s) begin
            if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
            // Phase counter keeps repeats going once hold has saturated.
            if (r_hold == HOLD_FIRE) begin
              r_long   <= 1'b1;
              r_phase  <= '0;
              r_repeat <= i_repeat_en;
            end else if (r_hold >= HOLD_RPT) begin
              if (r_phase == PH_LAST) begin
                r_phase  <= '0;
                r_repeat <= i_repeat_en;
              end else begin
                r_phase <= r_phase + 1'b1;
              end
            end
          end else if (DEBOUNCE_SAMPLES == 1) begin
            r_state <= IDLE;
            r_level <= 1'b0;
            r_long  <= 1'b0;
            r_hold  <= '0;
            r_phase <= '0;
            r_up    <= 1'b1;
          end else begin
            r_state <= RELEASE_CHK;
            r_deb   <= DW'(1);
          end
          RELEASE_CHK: if (i_s) begin
            r_state <= HELD;
            r_deb   <= '0;
          end else if (r_deb == DEB_LAST) begin
            r_state <= IDLE;
            r_deb   <= '0;
            r_level <= 1'b0;
            r_long  <= 1'b0;
            r_hold  <= '0;
            r_phase <= '0;
            r_up    <= 1'b1;
          end else begin
            r_deb <= r_deb + 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_level  = r_level;
  assign o_down   = r_down;
  assign o_up     = r_up;
  assign o_repeat = r_repeat;
  assign o_long   = r_long;
endmodule

module key_event_gen #(
  parameter int NUM_KEYS         = 2,
  parameter int ACTIVE_LOW       = 1,
  parameter int SAMPLE_DIV       = 1024,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int REPEAT_DELAY     = 64,
  parameter int REPEAT_RATE      = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] i_key_raw,
  input  logic [NUM_KEYS-1:0] i_repeat_en,
  output logic [NUM_KEYS-1:0] o_key_level,
  output logic [NUM_KEYS-1:0] o_key_down,
  output logic [NUM_KEYS-1:0] o_key_up,
  output logic [NUM_KEYS-1:0] o_key_repeat,
  output logic [NUM_KEYS-1:0] o_key_long
);
  localparam int PCW = $clog2(SAMPLE_DIV);
  localparam logic [PCW-1:0] PRESC_LAST = PCW'(SAMPLE_DIV - 1);
  // Synchroniser resets to the released pin level so no phantom press follows reset.
  localparam logic [NUM_KEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PCW-1:0]      r_presc;
  logic [NUM_KEYS-1:0] r_sync1, r_sync2;
  logic [NUM_KEYS-1:0] w_s;
  logic                w_tick;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_s    = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    key_event_lane #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_lane (
      .clock      (clock),
      .reset      (reset),
      .i_tick     (w_tick),
      .i_s        (w_s[g]),
      .i_repeat_en(i_repeat_en[g]),
      .o_level    (o_key_level[g]),
      .o_down     (o_key_down[g]),
      .o_up       (o_key_up[g]),
      .o_repeat   (o_key_repeat[g]),
      .o_long     (o_key_long[g])
    );
  end
endmodule
